rr_fifo_arbiter_param: RTL and testbench
========================================

Name: rr_fifo_arbiter_param

Overview:
Parametrised N-channel round-robin arbiter. Each channel has its own DEPTH-entry FIFO, and all channels drain into one registered output port with a valid/ready handshake.
Successor to the fixed 4x8 arbiter, with these additions:
- configurable channel count, data width and depth;
- work-conserving arbitration that skips empty channels;
- output backpressure;
- per-channel full and write-error flags.
It sits between producer lanes and a single shared downstream consumer.

Parameters:
N_CH, 4, number of input channels (>=2).
DATA_W, 8, data width per channel.
DEPTH, 8, entries per channel FIFO (power of 2, >=2).
CH_W, $clog2(N_CH), width of the channel index (derived; not overridden).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
wen  in  N_CH  per-channel write enable.
din  in  N_CH*DATA_W  packed write data; channel i occupies bits [i*DATA_W +: DATA_W].
full  out  N_CH  channel FIFO holds DEPTH entries (registered).
wr_err  out  N_CH  one-cycle pulse: a write to a full channel was dropped.
dout  out  DATA_W  output data; 0 whenever valid=0.
dout_ch  out  CH_W  source channel of dout; 0 whenever valid=0.
valid  out  1  dout/dout_ch hold an item.
ready  in  1  consumer accepts the item this cycle.

Behaviour:
- Reset: rst_n low clears state immediately, without waiting for a clock edge.
  - Cleared: all FIFO pointers and counts, the grant pointer (to 0), valid, dout, dout_ch, full, wr_err.
  - FIFO storage contents need not be cleared.
  - Reset mid-operation discards all queued and held items.
- Write side:
  - Channel i accepts din slice i at a rising edge when wen[i]=1 and full[i]=0.
  - If wen[i]=1 and full[i]=1: the write is dropped and wr_err[i]=1 for exactly the following cycle.
  - Writes are never blocked by the read side.
  - full is computed from the registered count only; a write to a full channel is dropped even if that channel is popped the same edge.
- Count per channel: width $clog2(DEPTH)+1.
  - Write+pop on the same edge leaves the count unchanged.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Load condition, evaluated each edge: load = (!valid) || (valid && ready).
- When load=1, candidates are channels with registered count>0, searched circularly starting at grant pointer g.
  - First candidate c found: pop its head into dout, set dout_ch=c, set valid=1, and set g to (c+1) mod N_CH.
  - No candidate: valid goes to 0 (if the held item was consumed), dout/dout_ch go to 0, and g is unchanged.
- When valid=1 and ready=0: dout, dout_ch, valid and g hold; no pop occurs.
- Latency:
  - An item written at edge T is eligible at edge T+1, so valid is earliest high after T+1.
  - Back-to-back throughput is one item per cycle with ready=1 and any channel non-empty.
- Capacity: one item can sit in the output register, so a channel absorbs up to DEPTH+1 items while ready=0.
- Fairness: under continuous ready=1 with all channels non-empty, output order is strictly g, g+1, ..., wrapping around.
- Ordering: each channel is FIFO-ordered; no reordering within a channel.

Decomposition:
- Shared package:
  - clog2 helper constant function;
  - default N_CH/DATA_W/DEPTH constants;
  - circular-next-index function used by the grant search.
- Sub-module sync_fifo_ch, instantiated N_CH times.
  - Parameters: DATA_W, DEPTH.
  - Ports: clk, rst_n, wen, ren, din, dout (combinational head), count, full, wr_err.
- The top level holds the grant pointer, the circular first-non-empty search and the output register.

Test Plan:
- Reset mid-operation: fill ch0 with 3 items, hold ready=0 with valid=1, drop rst_n between edges.
  -> valid/dout/full/wr_err are 0 immediately; after release with wen=0, valid stays 0 for 10 cycles.
- Fairness: write ch0..ch3 = {0x10,0x20,0x30,0x40}, then next cycle {0x11,0x21,0x31,0x41}; ready=1.
  -> output 0x10/ch0, 0x20/ch1, 0x30/ch2, 0x40/ch3, 0x11/ch0, 0x21/ch1, 0x31/ch2, 0x41/ch3 on consecutive cycles, then valid=0.
- Skip-empty: with g=1, only ch2 (0xA2) and ch0 (0xA0) non-empty, ready=1.
  -> 0xA2/ch2 then 0xA0/ch0; g ends at 1.
- Overflow: ready=0, write ch1 values 0x00..0x09 on 10 consecutive cycles.
  -> full[1]=1 after the 9th write; the 10th is dropped with wr_err[1]=1 for one cycle.
  -> with ready=1, output is 0x00..0x08 in order from ch1, then valid=0.
- Backpressure: valid=1 with 0x55/ch3 and ready=0 for 5 cycles while ch0..ch2 receive writes.
  -> dout=0x55, dout_ch=3 stable for 5 cycles; the next item is from ch0 after ready=1.
- Simultaneous write+pop: ch2 holds 4 items, ready=1, wen[2]=1 each cycle, other channels empty.
  -> count[2] stays 4, full[2]=0, and output is a continuous in-order ch2 stream.

Source files
------------

// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared constants and helpers for the round-robin FIFO arbiter.
// Used by the per-channel FIFO and by the grant search in the top level.
package rr_fifo_arbiter_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_fifo_arbiter_param_sync_fifo_ch.sv
// Single-channel synchronous FIFO with a combinational head.
// Full comes from the registered count, so a pop never frees a slot early.
module sync_fifo_ch
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW    = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              wr_err
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              push;
  logic              pop;

  assign full = (count == CW'(DEPTH));
  assign push = wen && !full;
  assign pop  = ren && (count != '0);
  assign dout = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      wr_err <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count  <= count + CW'(push) - CW'(pop);
      wr_err <= wen && full;
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter_param.sv
// N-channel round-robin arbiter draining per-channel FIFOs
// into one registered valid/ready output port.
module rr_fifo_arbiter_param
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CH_W   = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        wen,
  input  logic [N_CH*DATA_W-1:0] din,
  output logic [N_CH-1:0]        full,
  output logic [N_CH-1:0]        wr_err,
  output logic [DATA_W-1:0]      dout,
  output logic [CH_W-1:0]        dout_ch,
  output logic                   valid,
  input  logic                   ready
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [CW-1:0]     cnt  [N_CH];
  logic [DATA_W-1:0] head [N_CH];
  logic [N_CH-1:0]   ren;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic              load;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_fifo_ch #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (wen[i]),
      .ren   (ren[i]),
      .din   (din[i*DATA_W +: DATA_W]),
      .dout  (head[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .wr_err(wr_err[i])
    );
  end

  assign load = !valid || ready;

  // Circular first-non-empty search starting at the grant pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = g;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = CH_W'(next_idx(int'(idx), N_CH));
    end
  end

  always_comb begin
    ren = '0;
    if (load && found) ren[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g       <= '0;
      valid   <= 1'b0;
      dout    <= '0;
      dout_ch <= '0;
    end else if (load) begin
      if (found) begin
        dout    <= head[pick];
        dout_ch <= pick;
        valid   <= 1'b1;
        g       <= CH_W'(next_idx(int'(pick), N_CH));
      end else begin
        dout    <= '0;
        dout_ch <= '0;
        valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter_param.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_rr_fifo_arbiter_param;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CHW   = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    wen   = '0;
  logic [N*DW-1:0] din   = '0;
  logic            ready = 1'b0;
  logic [N-1:0]    full;
  logic [N-1:0]    wr_err;
  logic [DW-1:0]   dout;
  logic [CHW-1:0]  dout_ch;
  logic            valid;

  rr_fifo_arbiter_param #(
    .N_CH  (N),
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wen    (wen),
    .din    (din),
    .full   (full),
    .wr_err (wr_err),
    .dout   (dout),
    .dout_ch(dout_ch),
    .valid  (valid),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: one queue per channel plus the held output item.
  logic [DW-1:0] q [N][$];
  int            g_m;
  bit            v_m;
  logic [DW-1:0] d_m;
  int            ch_m;
  logic [N-1:0]  err_m;
  int            pre [N];
  bit            hit;
  int            c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) q[i].delete();
      g_m = 0; v_m = 0; d_m = '0; ch_m = 0; err_m = '0;
    end else begin
      for (int i = 0; i < N; i++) pre[i] = q[i].size();
      for (int i = 0; i < N; i++) err_m[i] = wen[i] && pre[i] == DEPTH;
      if (!v_m || ready) begin
        hit = 0;
        for (int k = 0; k < N; k++) begin
          c = (g_m + k) % N;
          if (!hit && pre[c] > 0) begin
            hit = 1;
            d_m = q[c].pop_front();
            ch_m = c;
            g_m = (c + 1) % N;
          end
        end
        v_m = hit;
        if (!hit) begin d_m = '0; ch_m = 0; end
      end
      for (int i = 0; i < N; i++)
        if (wen[i] && pre[i] < DEPTH) q[i].push_back(din[i*DW +: DW]);
    end
  end

  logic [N-1:0] full_m;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) full_m[i] = (q[i].size() == DEPTH);
    chk("valid", 32'(valid), 32'(v_m));
    chk("dout", 32'(dout), 32'(d_m));
    chk("dout_ch", 32'(dout_ch), ch_m);
    chk("full", 32'(full), 32'(full_m));
    chk("wr_err", 32'(wr_err), 32'(err_m));
  end

  task automatic step(input logic [N-1:0] w, input logic [N*DW-1:0] d,
                      input logic r);
    wen = w; din = d; ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DW-1:0] fair [8] = '{8'h10, 8'h20, 8'h30, 8'h40,
                              8'h11, 8'h21, 8'h31, 8'h41};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full", 32'(full), 0);
    rst_n = 1'b1;

    // fairness
    step(4'hF, 32'h40302010, 1'b1);
    chk("fair_lat", 32'(valid), 0);
    step(4'hF, 32'h41312111, 1'b1);
    chk("fair_d0", 32'(dout), 32'(fair[0]));
    for (int k = 1; k < 8; k++) begin
      step('0, '0, 1'b1);
      chk("fair_d", 32'(dout), 32'(fair[k]));
      chk("fair_ch", 32'(dout_ch), k % 4);
    end
    step('0, '0, 1'b1);
    chk("fair_end", 32'(valid), 0);

    // skip empty with g=1
    step(4'b0001, 32'h99, 1'b1);
    step('0, '0, 1'b1);
    chk("g1_pop", 32'(dout), 32'h99);
    step(4'b0101, 32'h00A200A0, 1'b1);
    chk("skip_idle", 32'(valid), 0);
    step('0, '0, 1'b1);
    chk("skip_a2", {24'(dout), 8'(dout_ch)}, 32'hA202);
    step('0, '0, 1'b1);
    chk("skip_a0", {24'(dout), 8'(dout_ch)}, 32'hA000);
    step(4'b0110, 32'h00B2B100, 1'b1);
    step('0, '0, 1'b1);
    chk("skip_g1", {24'(dout), 8'(dout_ch)}, 32'hB101);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("skip_end", 32'(valid), 0);

    // overflow on ch1
    for (int k = 0; k < 10; k++) begin
      step(4'b0010, 32'(k) << 8, 1'b0);
      if (k == 8) chk("ovf_full", 32'(full), 32'b0010);
      if (k == 8) chk("ovf_noerr", 32'(wr_err), 0);
    end
    chk("ovf_err", 32'(wr_err), 32'b0010);
    chk("ovf_hold", {24'(dout), 8'(dout_ch)}, 32'h0001);
    for (int k = 1; k <= 8; k++) begin
      step('0, '0, 1'b1);
      if (k == 1) chk("ovf_errclr", 32'(wr_err), 0);
      chk("ovf_d", {24'(dout), 8'(dout_ch)}, (32'(k) << 8) | 1);
    end
    step('0, '0, 1'b1);
    chk("ovf_end", 32'(valid), 0);

    // backpressure
    step(4'b1000, 32'h55000000, 1'b0);
    step('0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {24'(dout), 8'(dout_ch)}, 32'h5503);
      step(4'b0111, 32'h00636261 + 32'(k), 1'b0);
    end
    chk("bp_last", {24'(dout), 8'(dout_ch)}, 32'h5503);
    step('0, '0, 1'b1);
    chk("bp_next", {24'(dout), 8'(dout_ch)}, 32'h6100);
    repeat (20) step('0, '0, 1'b1);

    // simultaneous write and pop on ch2
    for (int k = 0; k < 5; k++) step(4'b0100, 32'(8'hA0 + k) << 16, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0100, 32'(8'hA4 + k) << 16, 1'b1);
      chk("wp_d", {24'(dout), 8'(dout_ch)}, (32'(8'hA0 + k) << 8) | 2);
      chk("wp_full", 32'(full[2]), 0);
    end
    repeat (12) step('0, '0, 1'b1);

    // reset mid-operation
    for (int k = 1; k <= 4; k++) step(4'b0001, 32'(k), 1'b0);
    chk("mid_valid", 32'(valid), 1);
    wen = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", {16'(dout), 8'(full), 4'(wr_err),
                    2'(dout_ch), 2'(valid)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step('0, '0, 1'b1);
      chk("post_rst", 32'(valid), 0);
    end

    // random traffic
    for (int k = 0; k < 1800; k++) begin
      int bias;
      bias = (k / 100) % 3;
      step(N'($urandom), $urandom,
           bias == 2 ? 1'b1 : (bias == 1 ? ($urandom % 4) != 0
                                         : ($urandom % 4) == 0));
    end
    repeat (40) step('0, '0, 1'b1);
    chk("drain", 32'(valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
